sprite_addr_gen: RTL and testbench
==================================

# sprite_addr_gen

Generates the per-pixel sprite RAM addresses and draw flags for the player and the bomb. It tracks frame-synchronous sprite positions, the player walk animation and the bomb fuse/explosion life cycle. It sits directly upstream of the colour mapper and drives its `addrPlayer`/`drawPlayer` and `addrBomb`/`drawBomb` inputs. The colour mapper resolves priority (bomb over player over terrain) and performs the sprite RAM lookup.

## Interface
Parameters:
- `PLAYER_BASE`, 11'd0: sprite RAM base of the player's 4 frames (16x16 each, 256 entries per frame).
- `BOMB_BASE`, 11'd1024: sprite RAM base of the bomb's 2 frames (frame 0 fuse, frame 1 explosion).
- `FUSE_FRAMES`, 120: video frames spent in FUSE.
- `BOOM_FRAMES`, 30: video frames spent in BOOM.
- `ANIM_DIV`, 8: video frames per player animation step.

Ports:
- `clk`, in, 1: pixel clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `VS`, in, 1: vertical sync, active low, synchronous to `clk`.
- `DrawX`, `DrawY`, in, 10 each: current pixel coordinate.
- `player_x`, `player_y`, in, 10 each: player top-left, live from game logic.
- `player_moving`, in, 1: the animation advances only while high.
- `player_left`, in, 1: mirror the player sprite horizontally.
- `bomb_drop`, in, 1: one-cycle request to drop the bomb.
- `bomb_x`, `bomb_y`, in, 10 each: bomb top-left, sampled on an accepted `bomb_drop`.
- `addrPlayer`, `addrBomb`, out, 11 each: sprite RAM addresses.
- `drawPlayer`, `drawBomb`, out, 1 each: pixel lies inside the sprite box.
- `bomb_busy`, out, 1: high when the FSM is not IDLE.
- `bomb_done`, out, 1: one-cycle pulse on the BOOM->IDLE transition.

## Operation
Frame tick:
- `frame_start` = registered falling edge of `VS` (VS high last cycle, low now).
- On `frame_start`, latch `player_x`/`player_y` and `player_left` into shadow registers.
- All drawing uses the shadow registers, so there is no mid-frame tearing.

Player animation:
- An 8-bit divider counts `frame_start` ticks while `player_moving` = 1.
- On reaching `ANIM_DIV`-1 the divider clears and the 2-bit `anim_frame` increments, wrapping 3->0.
- `player_moving` = 0 clears both the divider and `anim_frame` at the next `frame_start`.

Player address:
- `dx = DrawX - px`, `dy = DrawY - py`, 10-bit unsigned subtraction (wrap makes left/above large).
- Inside the box when `dx < 16 && dy < 16`.
- `col = left ? 15-dx[3:0] : dx[3:0]`.
- `addrPlayer = PLAYER_BASE + {anim_frame, dy[3:0], col}`, truncated to 11 bits.

Bomb FSM, states IDLE, FUSE, BOOM:
- IDLE: `bomb_drop` latches `bomb_x`/`bomb_y` and clears `life_cnt` (8-bit) -> FUSE. `drawBomb` is forced 0.
- FUSE: `life_cnt` increments on each `frame_start`. At `FUSE_FRAMES`-1, clear `life_cnt` -> BOOM. Uses frame 0.
- BOOM: same counting up to `BOOM_FRAMES`-1 -> IDLE, with `bomb_done` = 1 for that cycle. Uses frame 1.
- `addrBomb = BOMB_BASE + {frame, dy[3:0], dx[3:0]}`, computed against the bomb position. The bomb is never mirrored.

Boundary rules:
- `bomb_drop` outside IDLE is ignored.
- `bomb_drop` coinciding with `frame_start` in IDLE is accepted; that `frame_start` is not counted.
- The bomb position is live immediately on drop and is not frame-shadowed.
- Position near the 10-bit limit (e.g. x = 1020): the box wraps to x = 0..11 by arithmetic. This is permitted and not guarded.

## Timing
- All outputs are registered. `addrX`/`drawX` correspond to the `DrawX`/`DrawY` presented exactly one cycle earlier.
- The colour mapper's synchronous RAM adds one more cycle, for two cycles total pixel latency.
- Reset values: `addrPlayer` = 0, `addrBomb` = 0, `drawPlayer` = 0, `drawBomb` = 0, `bomb_busy` = 0, `bomb_done` = 0.
- Internal state on reset: FSM = IDLE, all counters, shadows and the edge register cleared.
- Reset asserted mid-FUSE/BOOM: outputs drop to reset values asynchronously. No `bomb_done` pulse is issued.
- `bomb_busy` goes high the cycle after an accepted drop, and low in the same cycle `bomb_done` pulses.

## Configuration
- `SPRITE_ANIM_EN` defined: the animation divider and `anim_frame` are built as described; `player_moving` is used.
- Not defined: `anim_frame` is a constant 0, `player_moving` is ignored, and no divider logic is built.
- Bomb frame selection is unaffected by the macro.

## Test plan
- Player box hit: shadow player at (100,50), frame 0, not mirrored; present DrawX=103, DrawY=52. Next cycle: `drawPlayer`=1, `addrPlayer`=35. Present DrawX=116: `drawPlayer`=0.
- Mirror: `player_left`=1 latched at (100,50); DrawX=100, DrawY=50 -> `addrPlayer`=15.
- Animation (`SPRITE_ANIM_EN` defined): moving=1, `ANIM_DIV`=8. After 8 `frame_start` ticks, `anim_frame`=1 and pixel (0,0) of the box -> `addrPlayer`=256. After 32 ticks it wraps to 0.
- Bomb life: drop at (200,300) with `FUSE_FRAMES`=120, `BOOM_FRAMES`=30.
  - Pixel (200,300) gives `addrBomb`=1024 during FUSE.
  - Gives 1280 after 120 frames.
  - `bomb_done` pulses once after 150 frames and `bomb_busy` falls.
  - A second `bomb_drop` during FUSE is ignored.
- Reset mid-BOOM: assert `reset_n`=0 → `drawBomb`=0, `bomb_busy`=0 immediately with no `bomb_done`. After release, a drop restarts a full 120-frame FUSE.
- Edge alignment: drop coinciding with a VS falling edge; the transition to BOOM occurs on the 120th subsequent `frame_start`, not the 119th.

Source files
------------

// File: rtl/sprite_addr_gen_if.sv
// sprite_addr_gen_if: pixel, player, bomb and sprite-address signals exchanged
// between the video/game side (master) and sprite_addr_gen (slave).
//
// Handshake: bomb_drop is a single-cycle request from the game logic. It is
// accepted only on a cycle where bomb_busy is low (bomb FSM idle), and
// bomb_x/bomb_y are captured on that same cycle. A drop while bomb_busy is
// high is dropped silently; there is no retry or queueing. bomb_done pulses
// for one cycle when the explosion ends, in the cycle bomb_busy falls.
interface sprite_addr_gen_if;
  logic        VS;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  player_x;
  logic [9:0]  player_y;
  logic        player_moving;
  logic        player_left;
  logic        bomb_drop;
  logic [9:0]  bomb_x;
  logic [9:0]  bomb_y;
  logic [10:0] addrPlayer;
  logic [10:0] addrBomb;
  logic        drawPlayer;
  logic        drawBomb;
  logic        bomb_busy;
  logic        bomb_done;

  modport master (
    output VS, DrawX, DrawY, player_x, player_y, player_moving, player_left,
           bomb_drop, bomb_x, bomb_y,
    input  addrPlayer, addrBomb, drawPlayer, drawBomb, bomb_busy, bomb_done
  );

  modport slave (
    input  VS, DrawX, DrawY, player_x, player_y, player_moving, player_left,
           bomb_drop, bomb_x, bomb_y,
    output addrPlayer, addrBomb, drawPlayer, drawBomb, bomb_busy, bomb_done
  );
endinterface

// File: rtl/sprite_addr_gen.sv
// sprite_addr_gen: per-pixel sprite RAM addresses and draw flags for the
// player (4-frame walk animation, optional mirroring) and the bomb
// (IDLE -> FUSE -> BOOM life cycle). All outputs are registered, one cycle
// after DrawX/DrawY.
// Build option: define SPRITE_ANIM_EN to build the walk-animation divider;
// otherwise the player always uses frame 0 and player_moving is ignored.
module sprite_addr_gen #(
  parameter logic [10:0] PLAYER_BASE = 11'd0,
  parameter logic [10:0] BOMB_BASE   = 11'd1024,
  parameter int          FUSE_FRAMES = 120,
  parameter int          BOOM_FRAMES = 30,
  parameter int          ANIM_DIV    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  sprite_addr_gen_if.slave  bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FUSE = 2'd1,
    S_BOOM = 2'd2
  } bomb_state_t;

  localparam logic [7:0] FUSE_LAST = 8'(FUSE_FRAMES - 1);
  localparam logic [7:0] BOOM_LAST = 8'(BOOM_FRAMES - 1);

  logic        r_vs_d;
  logic        w_frame_start;
  logic [9:0]  r_px;
  logic [9:0]  r_py;
  logic        r_left;
  logic [1:0]  w_anim_frame;
  bomb_state_t r_state;
  bomb_state_t w_next_state;
  logic [7:0]  r_life_cnt;
  logic [9:0]  r_bx;
  logic [9:0]  r_by;
  logic        w_accept;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_done;
  logic [9:0]  w_pdx;
  logic [9:0]  w_pdy;
  logic [9:0]  w_bdx;
  logic [9:0]  w_bdy;
  logic [3:0]  w_col;
  logic        w_p_in;
  logic        w_b_in;
  logic        w_bomb_frame;

  assign o_dbg_state = r_state;

  // Remember last VS so a high->low transition marks the start of a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_vs_d <= 1'b0;
    else          r_vs_d <= bus.VS;
  end

  assign w_frame_start = r_vs_d & ~bus.VS;

  // Shadow the player position/facing once per frame to avoid tearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_px   <= 10'd0;
      r_py   <= 10'd0;
      r_left <= 1'b0;
    end else if (w_frame_start) begin
      r_px   <= bus.player_x;
      r_py   <= bus.player_y;
      r_left <= bus.player_left;
    end
  end

`ifdef SPRITE_ANIM_EN
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_DIV - 1);

  logic [7:0] r_anim_div;
  logic [1:0] r_anim_frame;

  // Walk animation: step one frame every ANIM_DIV ticks while moving.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_anim_div   <= 8'd0;
      r_anim_frame <= 2'd0;
    end else if (w_frame_start) begin
      if (!bus.player_moving) begin
        r_anim_div   <= 8'd0;
        r_anim_frame <= 2'd0;
      end else if (r_anim_div == ANIM_LAST) begin
        r_anim_div   <= 8'd0;
        r_anim_frame <= r_anim_frame + 2'd1;
      end else begin
        r_anim_div   <= r_anim_div + 8'd1;
      end
    end
  end

  assign w_anim_frame = r_anim_frame;
`else
  localparam int ANIM_DIV_UNUSED = ANIM_DIV;

  logic w_unused_moving;

  assign w_unused_moving = bus.player_moving;
  assign w_anim_frame    = 2'd0;
`endif

  // Bomb FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Bomb FSM next state and counter controls; a drop in IDLE wins over any
  // coincident frame tick, so that tick is not counted.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.bomb_drop) begin
          w_accept     = 1'b1;
          w_cnt_clr    = 1'b1;
          w_next_state = S_FUSE;
        end
      end
      S_FUSE: begin
        if (w_frame_start) begin
          if (r_life_cnt == FUSE_LAST) begin
            w_cnt_clr    = 1'b1;
            w_next_state = S_BOOM;
          end else begin
            w_cnt_inc    = 1'b1;
          end
        end
      end
      S_BOOM: begin
        if (w_frame_start) begin
          if (r_life_cnt == BOOM_LAST) begin
            w_cnt_clr    = 1'b1;
            w_done       = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_cnt_inc    = 1'b1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Bomb life counter and drop position (live, not frame-shadowed).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_life_cnt <= 8'd0;
      r_bx       <= 10'd0;
      r_by       <= 10'd0;
    end else begin
      if (w_cnt_clr)      r_life_cnt <= 8'd0;
      else if (w_cnt_inc) r_life_cnt <= r_life_cnt + 8'd1;
      if (w_accept) begin
        r_bx <= bus.bomb_x;
        r_by <= bus.bomb_y;
      end
    end
  end

  // Box-relative offsets; wrap-around makes pixels left/above the box large.
  assign w_pdx        = bus.DrawX - r_px;
  assign w_pdy        = bus.DrawY - r_py;
  assign w_bdx        = bus.DrawX - r_bx;
  assign w_bdy        = bus.DrawY - r_by;
  assign w_col        = r_left ? (4'd15 - w_pdx[3:0]) : w_pdx[3:0];
  assign w_p_in       = (w_pdx < 10'd16) && (w_pdy < 10'd16);
  assign w_b_in       = (w_bdx < 10'd16) && (w_bdy < 10'd16);
  assign w_bomb_frame = (r_state == S_BOOM);

  // Registered outputs: addresses, draw flags and bomb status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.addrPlayer <= 11'd0;
      bus.addrBomb   <= 11'd0;
      bus.drawPlayer <= 1'b0;
      bus.drawBomb   <= 1'b0;
      bus.bomb_busy  <= 1'b0;
      bus.bomb_done  <= 1'b0;
    end else begin
      bus.addrPlayer <= PLAYER_BASE + {1'b0, w_anim_frame, w_pdy[3:0], w_col};
      bus.addrBomb   <= BOMB_BASE + {2'b00, w_bomb_frame, w_bdy[3:0], w_bdx[3:0]};
      bus.drawPlayer <= w_p_in;
      bus.drawBomb   <= w_b_in && (r_state != S_IDLE);
      bus.bomb_busy  <= (w_next_state != S_IDLE);
      bus.bomb_done  <= w_done;
    end
  end

endmodule

// File: tb/tb_sprite_addr_gen.sv
// tb_sprite_addr_gen: directed and randomized checks of sprite_addr_gen
// against a frame-level model (shadowed player, animation tick count, bomb
// age in frames since the drop).
`timescale 1ns/1ps
module tb_sprite_addr_gen;

  localparam int PLAYER_BASE = 0;
  localparam int BOMB_BASE   = 1024;
  localparam int FUSE_FRAMES = 120;
  localparam int BOOM_FRAMES = 30;
  localparam int ANIM_DIV    = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  sprite_addr_gen_if bus();

  sprite_addr_gen #(
    .PLAYER_BASE (11'(PLAYER_BASE)),
    .BOMB_BASE   (11'(BOMB_BASE)),
    .FUSE_FRAMES (FUSE_FRAMES),
    .BOOM_FRAMES (BOOM_FRAMES),
    .ANIM_DIV    (ANIM_DIV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done_seen = 0;
  int n_busy_at_done = 0;

  // Model state.
  int m_px = 0, m_py = 0, m_move_ticks = 0;
  bit m_left = 0;
  bit m_bomb_on = 0;
  int m_age = 0, m_bx = 0, m_by = 0;
  int m_done_exp = 0;

  // bomb_done pulse monitor.
  always @(negedge clk) begin
    if (bus.bomb_done === 1'b1) begin
      n_done_seen++;
      if (bus.bomb_busy !== 1'b0) n_busy_at_done++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_anim();
`ifdef SPRITE_ANIM_EN
    return (m_move_ticks / ANIM_DIV) % 4;
`else
    return 0;
`endif
  endfunction

  task automatic model_frame(input bit count_bomb);
    m_px   = int'(bus.player_x);
    m_py   = int'(bus.player_y);
    m_left = bus.player_left;
    if (bus.player_moving) m_move_ticks++;
    else                   m_move_ticks = 0;
    if (count_bomb && m_bomb_on) begin
      m_age++;
      if (m_age == FUSE_FRAMES + BOOM_FRAMES) begin
        m_bomb_on = 0;
        m_done_exp++;
      end
    end
  endtask

  task automatic model_reset();
    m_px = 0; m_py = 0; m_left = 0; m_move_ticks = 0;
    m_bomb_on = 0; m_age = 0; m_bx = 0; m_by = 0;
  endtask

  // One video frame: VS falls for a cycle, then returns high.
  task automatic frame();
    bus.VS = 1'b0;
    tick();
    model_frame(1);
    bus.VS = 1'b1;
    tick();
  endtask

  task automatic drop(input int x, input int y, input bit with_vs);
    bit was_on;
    bus.bomb_x    = 10'(x);
    bus.bomb_y    = 10'(y);
    bus.bomb_drop = 1'b1;
    if (with_vs) bus.VS = 1'b0;
    tick();
    was_on = m_bomb_on;
    if (!was_on) begin
      m_bomb_on = 1; m_age = 0; m_bx = x; m_by = y;
    end
    if (with_vs) model_frame(was_on);
    bus.bomb_drop = 1'b0;
    bus.VS        = 1'b1;
    if (with_vs) tick();
  endtask

  // Present a pixel for one cycle and compare all per-pixel outputs.
  task automatic pix(input int x, input int y, input string tag);
    int dx, dy, col, bdx, bdy, exp_pa, exp_ba;
    bit p_in, b_in;
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    tick();
    dx  = (x - m_px) & 1023;
    dy  = (y - m_py) & 1023;
    p_in = (dx < 16) && (dy < 16);
    col = m_left ? 15 - (dx & 15) : (dx & 15);
    exp_pa = (PLAYER_BASE + model_anim() * 256 + (dy & 15) * 16 + col) & 2047;
    bdx = (x - m_bx) & 1023;
    bdy = (y - m_by) & 1023;
    b_in = (bdx < 16) && (bdy < 16);
    exp_ba = (BOMB_BASE + ((m_bomb_on && m_age >= FUSE_FRAMES) ? 256 : 0)
              + (bdy & 15) * 16 + (bdx & 15)) & 2047;
    check({tag, ".drawPlayer"}, 32'(bus.drawPlayer), 32'(p_in));
    check({tag, ".addrPlayer"}, 32'(bus.addrPlayer), 32'(exp_pa));
    check({tag, ".drawBomb"},   32'(bus.drawBomb),   32'(m_bomb_on && b_in));
    check({tag, ".addrBomb"},   32'(bus.addrBomb),   32'(exp_ba));
    check({tag, ".bomb_busy"},  32'(bus.bomb_busy),  32'(m_bomb_on));
  endtask

  int done_before;
  int rx, ry;

  initial begin
    bus.VS = 1'b1; bus.DrawX = '0; bus.DrawY = '0;
    bus.player_x = '0; bus.player_y = '0;
    bus.player_moving = 1'b0; bus.player_left = 1'b0;
    bus.bomb_drop = 1'b0; bus.bomb_x = '0; bus.bomb_y = '0;

    // Reset values.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.addrPlayer", 32'(bus.addrPlayer), 0);
    check("rst.addrBomb",   32'(bus.addrBomb),   0);
    check("rst.drawPlayer", 32'(bus.drawPlayer), 0);
    check("rst.drawBomb",   32'(bus.drawBomb),   0);
    check("rst.bomb_busy",  32'(bus.bomb_busy),  0);
    check("rst.bomb_done",  32'(bus.bomb_done),  0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();

    // Player box hit and miss.
    bus.player_x = 10'd100; bus.player_y = 10'd50;
    frame();
    pix(103, 52, "box_hit");
    check("box_hit.const_addr", 32'(bus.addrPlayer), 35);
    check("box_hit.const_draw", 32'(bus.drawPlayer), 1);
    pix(116, 52, "box_miss_x");
    check("box_miss_x.const", 32'(bus.drawPlayer), 0);
    pix(103, 66, "box_miss_y");
    pix(99, 52, "box_miss_left");

    // Mirror and shadow hold.
    bus.player_left = 1'b1;
    frame();
    pix(100, 50, "mirror");
    check("mirror.const", 32'(bus.addrPlayer), 15);
    bus.player_x = 10'd300;
    pix(100, 50, "shadow_hold");
    check("shadow_hold.const", 32'(bus.drawPlayer), 1);

    // Animation.
    bus.player_x = 10'd100; bus.player_left = 1'b0; bus.player_moving = 1'b1;
    repeat (8) frame();
    pix(100, 50, "anim8");
`ifdef SPRITE_ANIM_EN
    check("anim8.const", 32'(bus.addrPlayer), 256);
`else
    check("anim8.const", 32'(bus.addrPlayer), 0);
`endif
    repeat (24) frame();
    pix(100, 50, "anim32");
    check("anim32.const", 32'(bus.addrPlayer), 0);
    repeat (13) frame();
    bus.player_moving = 1'b0;
    frame();
    pix(101, 51, "anim_stop");

    // Box wrap near the 10-bit limit.
    bus.player_x = 10'd1020;
    frame();
    pix(5, 50, "wrap_in");
    check("wrap_in.const", 32'(bus.drawPlayer), 1);
    pix(12, 50, "wrap_out");

    // Bomb life cycle.
    bus.player_x = 10'd100;
    frame();
    drop(200, 300, 0);
    check("drop.busy_const", 32'(bus.bomb_busy), 1);
    pix(200, 300, "fuse");
    check("fuse.const_addr", 32'(bus.addrBomb), 1024);
    drop(0, 0, 0);
    pix(200, 300, "fuse_redrop");
    check("fuse_redrop.const", 32'(bus.drawBomb), 1);
    repeat (119) frame();
    pix(200, 300, "fuse119");
    check("fuse119.const", 32'(bus.addrBomb), 1024);
    frame();
    pix(200, 300, "boom120");
    check("boom120.const", 32'(bus.addrBomb), 1280);
    done_before = n_done_seen;
    repeat (29) frame();
    check("boom149.no_done", 32'(n_done_seen), 32'(done_before));
    check("boom149.busy", 32'(bus.bomb_busy), 1);
    frame();
    check("boom150.done_once", 32'(n_done_seen), 32'(done_before + 1));
    check("boom150.busy_low", 32'(bus.bomb_busy), 0);
    check("done_vs_busy", 32'(n_busy_at_done), 0);
    pix(200, 300, "idle_after");
    check("idle_after.const", 32'(bus.drawBomb), 0);

    // Randomized frames, moves, drops and pixels.
    for (int f = 0; f < 180; f++) begin
      bus.player_x = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(1000, 1023))
                                                : 10'($urandom_range(0, 1023));
      bus.player_y = 10'($urandom_range(0, 1023));
      bus.player_left   = 1'($urandom_range(0, 1));
      bus.player_moving = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 14) == 0)
        drop(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
             1'($urandom_range(0, 1)));
      else
        frame();
      for (int k = 0; k < 2; k++) begin
        if (m_bomb_on && $urandom_range(0, 1) == 1) begin
          rx = (m_bx + int'($urandom_range(0, 19)) - 2) & 1023;
          ry = (m_by + int'($urandom_range(0, 19)) - 2) & 1023;
        end else begin
          rx = (m_px + int'($urandom_range(0, 19)) - 2) & 1023;
          ry = (m_py + int'($urandom_range(0, 19)) - 2) & 1023;
        end
        pix(rx, ry, "rand");
      end
    end
    check("rand.done_count", 32'(n_done_seen), 32'(m_done_exp));

    // Finish any bomb left over, then reset in the middle of BOOM.
    repeat (160) frame();
    bus.player_moving = 1'b0;
    drop(400, 100, 0);
    repeat (125) frame();
    pix(400, 100, "pre_reset");
    check("pre_reset.const_draw", 32'(bus.drawBomb), 1);
    check("pre_reset.const_addr", 32'(bus.addrBomb), 1280);
    done_before = n_done_seen;
    reset_n = 1'b0;
    #2;
    check("async_rst.drawBomb",   32'(bus.drawBomb),   0);
    check("async_rst.bomb_busy",  32'(bus.bomb_busy),  0);
    check("async_rst.bomb_done",  32'(bus.bomb_done),  0);
    check("async_rst.addrBomb",   32'(bus.addrBomb),   0);
    check("async_rst.drawPlayer", 32'(bus.drawPlayer), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();
    check("async_rst.no_done", 32'(n_done_seen), 32'(done_before));

    // Drop coinciding with a VS falling edge: that tick is not counted.
    drop(200, 300, 1);
    pix(200, 300, "align0");
    repeat (119) frame();
    pix(200, 300, "align119");
    check("align119.const", 32'(bus.addrBomb), 1024);
    frame();
    pix(200, 300, "align120");
    check("align120.const", 32'(bus.addrBomb), 1280);
    repeat (30) frame();
    check("align.done", 32'(n_done_seen), 32'(done_before + 1));
    check("final.done_count", 32'(n_done_seen), 32'(m_done_exp));
    check("final.done_vs_busy", 32'(n_busy_at_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
